// File: rtl/wb_pwm_pkg.sv
// Shared definitions for the Wishbone PWM peripherals: register word offsets,
// STATUS/CTRL bit positions and the capture FSM state encoding.
package wb_pwm_pkg;

   // Register word index, taken from byte address bits [3:2]
   localparam logic [1:0] REG_PERIOD = 2'd0;  // 0x00
   localparam logic [1:0] REG_HIGH   = 2'd1;  // 0x04
   localparam logic [1:0] REG_STATUS = 2'd2;  // 0x08
   localparam logic [1:0] REG_CTRL   = 2'd3;  // 0x0C

   // STATUS bits (write-1-to-clear)
   localparam int ST_VALID   = 0;
   localparam int ST_TIMEOUT = 1;
   localparam int ST_OVERRUN = 2;

   // CTRL bits
   localparam int CT_ENABLE = 0;
   localparam int CT_IRQ_EN = 1;

   typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} cap_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the asynchronous PWM input, followed by a
// registered edge detector producing one-cycle rise/fall pulses.
module pwm_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic s1, s2, prev;

   // Synchronize, then compare against the previous synchronized sample
   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1   <= din;
         s2   <= s1;
         prev <= s2;
         rise <= s2 & ~prev;
         fall <= ~s2 & prev;
      end
   end

endmodule

// File: rtl/wb_pwm_capture.sv
// Wishbone slave that measures period and high time of an external PWM
// signal in microseconds, with valid/timeout/overrun status and interrupt.
module wb_pwm_capture
   import wb_pwm_pkg::*;
#(
   parameter int unsigned CLKS_PER_US = 50,
   parameter int unsigned TIMEOUT_US  = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic        pwm_in,
   output logic        irq_o
);

   localparam int PW = $clog2(CLKS_PER_US);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_US - 1);
   localparam logic [31:0]   CNT_LAST   = 32'(TIMEOUT_US - 1);

   logic          rise, fall;
   logic [PW-1:0] presc;
   logic [31:0]   us_cnt;
   logic          tick;
   logic [31:0]   meas;
   logic          to_expire;

   cap_state_e    state, state_nxt;
   logic          complete, capture_high, to_hit;

   logic [31:0]   period_r, high_r, high_shadow;
   logic [2:0]    status_r, status_nxt, w1c;
   logic [1:0]    ctrl_r;
   logic          ack_r;
   logic          acc, wr;
   logic [1:0]    adr_idx;
   logic [31:0]   rdata;

   logic          unused_bits;
   assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:3]};

   pwm_edge_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (pwm_in),
      .rise  (rise),
      .fall  (fall)
   );

   assign tick = (presc == PRESC_LAST);
   // Counting the current cycle's tick makes the result floor(cycles/CLKS_PER_US)
   assign meas = us_cnt + {31'd0, tick};
   // A rise restarts the count, so it can never coincide with a timeout
   assign to_expire = tick & (us_cnt == CNT_LAST) & ~rise;

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and measurement strobes; disable overrides everything
   always_comb begin
      state_nxt    = state;
      complete     = 1'b0;
      capture_high = 1'b0;
      to_hit       = 1'b0;
      if (!ctrl_r[CT_ENABLE]) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: state_nxt = ARM;
            ARM:  if (rise) state_nxt = HIGH;
            HIGH: begin
               if (to_expire) begin
                  state_nxt = ARM;
                  to_hit    = 1'b1;
               end else if (fall) begin
                  state_nxt    = LOW;
                  capture_high = 1'b1;
               end
            end
            LOW: begin
               if (rise) begin
                  state_nxt = HIGH;
                  complete  = 1'b1;
               end else if (to_expire) begin
                  state_nxt = ARM;
                  to_hit    = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Prescaler and microsecond counter; run only while measuring, restart on rise
   always_ff @(posedge clk) begin
      if (reset) begin
         presc  <= '0;
         us_cnt <= '0;
      end else if (rise || !(state_nxt == HIGH || state_nxt == LOW)) begin
         presc  <= '0;
         us_cnt <= '0;
      end else if (tick) begin
         presc  <= '0;
         us_cnt <= us_cnt + 32'd1;
      end else begin
         presc  <= presc + PW'(1);
      end
   end

   assign acc     = wb_stb_i & wb_cyc_i & ~ack_r;
   assign wr      = acc & wb_we_i;
   assign adr_idx = wb_adr_i[3:2];
   assign w1c     = (wr && adr_idx == REG_STATUS) ? wb_dat_i[2:0] : 3'd0;

   // Status update: hardware sets take priority over software clears
   always_comb begin
      status_nxt = status_r & ~w1c;
      if (complete)                      status_nxt[ST_VALID]   = 1'b1;
      if (complete && status_r[ST_VALID]) status_nxt[ST_OVERRUN] = 1'b1;
      if (to_hit)                        status_nxt[ST_TIMEOUT] = 1'b1;
   end

   // Result, status and control registers
   always_ff @(posedge clk) begin
      if (reset) begin
         period_r    <= '0;
         high_r      <= '0;
         high_shadow <= '0;
         status_r    <= '0;
         ctrl_r      <= '0;
      end else begin
         if (capture_high) high_shadow <= meas;
         if (complete) begin
            period_r <= meas;
            high_r   <= high_shadow;
         end
         status_r <= status_nxt;
         if (wr && adr_idx == REG_CTRL) ctrl_r <= wb_dat_i[1:0];
      end
   end

   // Read mux; unused bits read as zero
   always_comb begin
      rdata = '0;
      case (adr_idx)
         REG_PERIOD: rdata = period_r;
         REG_HIGH:   rdata = high_r;
         REG_STATUS: rdata = {29'd0, status_r};
         REG_CTRL:   rdata = {30'd0, ctrl_r};
         default:    rdata = '0;
      endcase
   end

   // Two-cycle bus handshake with registered read data
   always_ff @(posedge clk) begin
      if (reset) begin
         ack_r    <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         ack_r <= acc;
         if (acc) wb_dat_o <= rdata;
      end
   end

   assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_r;
   assign irq_o    = ctrl_r[CT_IRQ_EN] & (status_r[ST_VALID] | status_r[ST_TIMEOUT]);

endmodule

// File: tb/tb_wb_pwm_capture.sv
// Self-checking bench for wb_pwm_capture: directed table of waveforms,
// multi-cycle corner sequences and a randomized stream against a model.
module tb_wb_pwm_capture;
   import wb_pwm_pkg::*;

   localparam int C = 2;      // clocks per microsecond
   localparam int T = 3000;   // timeout in microseconds

   localparam logic [3:0] A_PERIOD = 4'h0;
   localparam logic [3:0] A_HIGH   = 4'h4;
   localparam logic [3:0] A_STATUS = 4'h8;
   localparam logic [3:0] A_CTRL   = 4'hC;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        pwm_in, irq_o;

   always #5 clk = ~clk;

   wb_pwm_capture #(.CLKS_PER_US(C), .TIMEOUT_US(T)) dut (
      .clk      (clk),
      .reset    (reset),
      .wb_stb_i (wb_stb_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_ack_o (wb_ack_o),
      .wb_we_i  (wb_we_i),
      .wb_adr_i (wb_adr_i),
      .wb_sel_i (wb_sel_i),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .pwm_in   (pwm_in),
      .irq_o    (irq_o)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          h;    // high time in clk cycles
      int          l;    // low time in clk cycles
      logic [31:0] p;    // expected PERIOD (us)
      logic [31:0] hi;   // expected HIGH (us)
   } vec_t;

   typedef struct { int h; int l; } seg_t;

   vec_t tbl[6];
   seg_t hist[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic we, input logic [3:0] adr, input logic [31:0] wd,
                      output logic [31:0] rd);
      int  lat;
      bit  got;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = {28'd0, adr};
      wb_dat_i = wd;
      wb_sel_i = 4'hF;
      lat = 0;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(posedge clk);
         #1;
         lat++;
         if (wb_ack_o) got = 1'b1;
      end
      rd = wb_dat_o;
      check("ack_latency", lat, 1);
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i  = 1'b0;
      tick(1);
   endtask

   task automatic rd_chk(input logic [3:0] adr, input logic [31:0] exp, input string name);
      logic [31:0] d;
      bus(1'b0, adr, 32'd0, d);
      check(name, d, exp);
   endtask

   task automatic wr(input logic [3:0] adr, input logic [31:0] d);
      logic [31:0] dummy;
      bus(1'b1, adr, d, dummy);
   endtask

   task automatic restart(input logic [31:0] ctrl);
      wr(A_CTRL, 32'd0);
      pwm_in = 1'b0;
      tick(6);
      wr(A_STATUS, 32'd7);
      wr(A_CTRL, ctrl);
      tick(2);
   endtask

   task automatic pulse(input int h, input int l);
      pwm_in = 1'b1;
      tick(h);
      pwm_in = 1'b0;
      tick(l);
   endtask

   function automatic logic [31:0] to_us(input int cycles);
      return 32'(cycles / C);
   endfunction

   initial begin
      // Directed waveforms, expected values worked out by hand at 2 clk/us
      tbl[0] = '{h: 300, l: 3700, p: 2000, hi: 150};
      tbl[1] = '{h: 501, l: 1500, p: 1000, hi: 250};
      tbl[2] = '{h: 3,   l: 2,    p: 2,    hi: 1};
      tbl[3] = '{h: 2,   l: 3,    p: 2,    hi: 1};
      tbl[4] = '{h: 201, l: 800,  p: 500,  hi: 100};
      tbl[5] = '{h: 7,   l: 2,    p: 4,    hi: 3};

      reset    = 1'b1;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i  = 1'b0;
      wb_adr_i = '0;
      wb_dat_i = '0;
      wb_sel_i = '0;
      pwm_in   = 1'b0;
      tick(4);
      reset = 1'b0;
      tick(1);

      // Reset state
      check("rst_ack", 32'(wb_ack_o), 0);
      check("rst_dat", wb_dat_o, 0);
      check("rst_irq", 32'(irq_o), 0);
      check("rst_fsm", 32'(dut.state), 32'(IDLE));
      rd_chk(A_PERIOD, 0, "rst_period");
      rd_chk(A_HIGH,   0, "rst_high");
      rd_chk(A_STATUS, 0, "rst_status");
      rd_chk(A_CTRL,   0, "rst_ctrl");
      check("rst_irq2", 32'(irq_o), 0);

      // Table-driven single-period measurements
      for (int i = 0; i < 6; i++) begin
         restart(32'd3);
         pulse(tbl[i].h, tbl[i].l);
         pwm_in = 1'b1;
         tick(3);
         check("irq_before_done", 32'(irq_o), 0);
         tick(1);
         check("irq_at_done", 32'(irq_o), 1);
         rd_chk(A_PERIOD, tbl[i].p,  "tbl_period");
         rd_chk(A_HIGH,   tbl[i].hi, "tbl_high");
         rd_chk(A_STATUS, 32'd1,     "tbl_status");
         wr(A_STATUS, 32'd1);
         rd_chk(A_STATUS, 32'd0, "tbl_status_clr");
         check("tbl_irq_clr", 32'(irq_o), 0);
      end
      rd_chk(A_CTRL, 32'd3, "ctrl_readback");

      // Overrun: three completions without clearing valid
      restart(32'd3);
      for (int i = 0; i < 3; i++) pulse(500, 1500);
      pwm_in = 1'b1;
      tick(5);
      rd_chk(A_STATUS, 32'd5,    "ovr_status");
      rd_chk(A_PERIOD, 32'd1000, "ovr_period");
      rd_chk(A_HIGH,   32'd250,  "ovr_high");

      // Timeout on a constant-high input, then recovery
      restart(32'd3);
      pwm_in = 1'b1;
      tick(3 + T * C);
      check("to_before", 32'(irq_o), 0);
      tick(1);
      check("to_irq", 32'(irq_o), 1);
      check("to_fsm_arm", 32'(dut.state), 32'(ARM));
      rd_chk(A_STATUS, 32'd2,    "to_status");
      rd_chk(A_PERIOD, 32'd1000, "to_period_kept");
      pwm_in = 1'b0;
      tick(10);
      pulse(201, 800);
      pwm_in = 1'b1;
      tick(5);
      rd_chk(A_PERIOD, 32'd500, "to_rec_period");
      rd_chk(A_HIGH,   32'd100, "to_rec_high");
      rd_chk(A_STATUS, 32'd3,   "to_rec_status");

      // W1C of valid landing on the completion edge: the set wins
      restart(32'd3);
      pulse(20, 20);
      pwm_in = 1'b1;
      tick(3);
      wr(A_STATUS, 32'd1);
      rd_chk(A_STATUS, 32'd1, "w1c_race_status");
      rd_chk(A_PERIOD, 32'd20, "w1c_race_period");

      // Disable in LOW, re-enable, results retained until the new completion
      restart(32'd3);
      pulse(300, 100);
      wr(A_CTRL, 32'd0);
      check("dis_fsm_idle", 32'(dut.state), 32'(IDLE));
      wr(A_CTRL, 32'd3);
      tick(10);
      pwm_in = 1'b1;
      tick(10);
      rd_chk(A_PERIOD, 32'd20, "dis_period_kept");
      rd_chk(A_HIGH,   32'd10, "dis_high_kept");
      rd_chk(A_STATUS, 32'd0,  "dis_status");
      tick(185);
      pwm_in = 1'b0;
      tick(800);
      pwm_in = 1'b1;
      tick(5);
      rd_chk(A_PERIOD, 32'd500, "dis_new_period");
      rd_chk(A_HIGH,   32'd100, "dis_new_high");

      // Randomized stream: read and clear after every completion
      restart(32'd3);
      for (int i = 0; i <= 12; i++) begin
         int   spent;
         seg_t s;
         pwm_in = 1'b1;
         spent  = 0;
         if (i > 0) begin
            seg_t prev;
            prev = hist.pop_front();
            tick(5);
            rd_chk(A_PERIOD, to_us(prev.h + prev.l), "rnd_period");
            rd_chk(A_HIGH,   to_us(prev.h),          "rnd_high");
            rd_chk(A_STATUS, 32'd1,                  "rnd_status");
            wr(A_STATUS, 32'd7);
            spent = 13;
         end
         if (i == 12) break;
         s.h = 20 + int'($urandom_range(0, 300));
         s.l = 2 + int'($urandom_range(0, 300));
         hist.push_back(s);
         tick(s.h - spent);
         pwm_in = 1'b0;
         tick(s.l);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
